fp_int64_to_fp_serial: RTL and testbench
========================================

# fp_int64_to_fp_serial

Multi-cycle converter from 64-bit integers to FP32/FP64 for FCVT.S.L, FCVT.S.LU, FCVT.D.L and FCVT.D.LU. It sits next to the combinational 32-bit converter in the FP execution stage and takes these commands over a valid/ready request channel. It normalizes the magnitude with an iterative shifter, rounds according to `roundingMode`, and returns the NaN-boxed or full-width FP result with fflags over a valid/ready response channel.

## Interface
- `SHIFT_PER_CYCLE`, 4: coarse normalization shift per cycle; legal values 1, 2, 4, 8.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-low (already decided).
- `reqValid`  in  1  request valid.
- `reqReady`  out  1  block can accept a request.
- `command`  in  FpConverterCommand  one of S_L, S_LU, D_L, D_LU.
- `roundingMode`  in  3  resolved FRM (RNE/RTZ/RDN/RUP/RMM).
- `intSrc`  in  uint64_t  integer operand.
- `respValid`  out  1  result valid.
- `respReady`  in  1  consumer accepts result.
- `fpResult`  out  uint64_t  FP result; S results NaN-boxed.
- `writeFlagsValue`  out  fflags_t  exception flags for the result.

## Operation
- States: IDLE, NORMALIZE, ROUND, DONE.
- `reqReady` = (state == IDLE). `respValid` = (state == DONE).
- **IDLE**, on `reqValid` with a legal command:
  - Capture isDouble, `roundingMode`, and sign = signed && `intSrc[63]`.
  - Capture the 64-bit magnitude: mag = sign ? -intSrc : intSrc. Note -2^63 gives 0x8000_0000_0000_0000 unsigned.
  - Clear lz.
  - If mag == 0, go to DONE with result +0 and flags 0. Otherwise go to NORMALIZE.
  - A request carrying an illegal command is consumed and dropped; no response.
- **NORMALIZE**, one action per cycle:
  - If mag[63] == 1, go to ROUND.
  - Else if the top `SHIFT_PER_CYCLE` bits are all zero, mag <<= K and lz += K.
  - Else mag <<= 1 and lz += 1.
- **ROUND**, F = 23 (S) or 52 (D), bias 127 or 1023:
  - exponent = 63 - lz + bias.
  - fraction = mag[62:63-F].
  - g = mag[62-F], r = mag[61-F], s = OR of mag[60-F:0].
- **Increment rules:**
  - RNE: g && (r|s|fraction[0]).
  - RTZ: never.
  - RDN: sign && (g|r|s).
  - RUP: !sign && (g|r|s).
  - RMM: g.
  - Codes 5–7: treated as RNE.
- **Carry:** a carry out of fraction sets fraction = 0 and exponent += 1. Overflow is impossible because 2^64 < FP32 max.
- **Flags:** NX = g|r|s. NV, DZ, OF and UF are always 0.
- **Result:** S = {32'hffff_ffff, sign, exp[7:0], frac[22:0]}. D = {sign, exp[10:0], frac[51:0]}. The result is registered on entry to DONE.
- **DONE:** hold `fpResult` and `writeFlagsValue` stable until `respReady`. On handshake, go to IDLE. A new request is not accepted in the same cycle.
- **Reset:**
  - state = IDLE, so `reqReady` = 1 and `respValid` = 0.
  - `fpResult` = 0, `writeFlagsValue` = 0, internal mag and lz = 0.
  - Assertion at any time aborts the in-flight conversion; no response is produced.

## Timing
- Request accepted at edge E0.
- Zero input: DONE from cycle E0+1.
- Nonzero input, with N = floor(lz/K) + (lz mod K):
  - NORMALIZE occupies cycles E0+1 .. E0+1+N.
  - ROUND is at E0+2+N.
  - `respValid` is first high at E0+3+N.
- Examples, K=4: lz=0 gives respValid at E0+3; lz=63 (N=18) gives respValid at E0+21.
- Unpipelined: at most one transaction in flight. Minimum request-to-request spacing is the response handshake plus one cycle.
- `fpResult` and `writeFlagsValue` are valid only while `respValid`; they change only on the edge entering DONE or on reset.

## Configuration
- `FP_INT64_CVT_LZC_EN` defined:
  - NORMALIZE computes lz with a 64-bit leading-zero counter and a barrel shift in its single cycle; `SHIFT_PER_CYCLE` is ignored.
  - Nonzero latency is fixed: `respValid` at E0+3.
- Not defined: iterative shifter as described above, with data-dependent latency.
- Results and flags are identical in both builds.

## Test plan
- D_L, intSrc=0x0020_0000_0000_0001 (2^53+1), RNE → 0x4340_0000_0000_0000, NX=1. Same input with RUP → 0x4340_0000_0000_0001, NX=1.
- S_L, intSrc=0xFFFF_FFFF_FFFF_FFFF (-1) → 0xFFFF_FFFF_BF80_0000, flags 0. respValid at E0+21 for K=4 (non-LZC build), E0+3 for the LZC build.
- S_LU, intSrc=0xFFFF_FFFF_FFFF_FFFF: RNE → 0xFFFF_FFFF_5F80_0000, NX=1; RTZ → 0xFFFF_FFFF_5F7F_FFFF, NX=1.
- D_L, intSrc=0x8000_0000_0000_0000 → 0xC3E0_0000_0000_0000, NX=0. D_LU, intSrc=0 → 0x0, respValid at E0+1.
- Backpressure: hold respReady=0 for 5 cycles in DONE → respValid, fpResult and flags stable and reqReady=0. Handshake on the next edge → reqReady=1 the following cycle.
- Assert rst mid-NORMALIZE → respValid=0 and fpResult=0 immediately. A subsequent D_L request of 1 → 0x3FF0_0000_0000_0000.

Source files
------------

// File: rtl/fp_int64_to_fp_serial.sv
// Multi-cycle 64-bit integer to FP32/FP64 converter (FCVT.{S,D}.{L,LU}).
// Define FP_INT64_CVT_LZC_EN to replace the iterative shifter with a one-cycle LZC + barrel shift.
module fp_int64_to_fp_serial #(
  parameter int unsigned SHIFT_PER_CYCLE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  command,
  input  logic [2:0]  rounding_mode,
  input  logic [63:0] int_src,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] fp_result,
  output logic [4:0]  write_flags_value
);

  // command: 0 = S_L, 1 = S_LU, 2 = D_L, 3 = D_LU; 4..7 are illegal and dropped.
  typedef enum logic [1:0] {StIdle, StNormalize, StRound, StDone} state_e;

  state_e      state_q, state_d;
  logic        is_double_q, is_double_d;
  logic        sign_q, sign_d;
  logic [2:0]  rm_q, rm_d;
  logic [63:0] mag_q, mag_d;
  logic [5:0]  lz_q, lz_d;
  logic [63:0] result_q, result_d;
  logic [4:0]  flags_q, flags_d;

  logic        src_sign;
  logic [63:0] src_mag;

  logic [22:0] frac_s, frac_s_rnd;
  logic [51:0] frac_d, frac_d_rnd;
  logic        g, r, s, lsb, inc, carry_s, carry_d;
  logic [10:0] exp_base, exp_rnd;
  logic [63:0] rnd_result;
  logic        rnd_nx;

  assign req_ready         = (state_q == StIdle);
  assign resp_valid        = (state_q == StDone);
  assign fp_result         = result_q;
  assign write_flags_value = flags_q;

  // Signed commands have command[0] == 0; -2^63 negates to itself, which is the right magnitude.
  assign src_sign = ~command[0] & int_src[63];
  assign src_mag  = src_sign ? (~int_src + 64'd1) : int_src;

`ifdef FP_INT64_CVT_LZC_EN
  logic [5:0] lzc;
  always_comb begin
    lzc = '0;
    for (int i = 0; i < 64; i++) begin
      if (mag_q[i]) lzc = 6'(63 - i);
    end
  end
`endif

  // Rounding datapath; mag_q is normalized (bit 63 set) whenever this is consumed.
  always_comb begin
    frac_s = mag_q[62:40];
    frac_d = mag_q[62:11];
    if (is_double_q) begin
      g        = mag_q[10];
      r        = mag_q[9];
      s        = |mag_q[8:0];
      lsb      = frac_d[0];
      exp_base = 11'd1086 - {5'd0, lz_q};
    end else begin
      g        = mag_q[39];
      r        = mag_q[38];
      s        = |mag_q[37:0];
      lsb      = frac_s[0];
      exp_base = 11'd190 - {5'd0, lz_q};
    end
    case (rm_q)
      3'd1:    inc = 1'b0;
      3'd2:    inc = sign_q & (g | r | s);
      3'd3:    inc = ~sign_q & (g | r | s);
      3'd4:    inc = g;
      default: inc = g & (r | s | lsb);
    endcase
    {carry_s, frac_s_rnd} = {1'b0, frac_s} + {23'd0, inc};
    {carry_d, frac_d_rnd} = {1'b0, frac_d} + {52'd0, inc};
    if (is_double_q) begin
      exp_rnd    = exp_base + {10'd0, carry_d};
      rnd_result = {sign_q, exp_rnd, frac_d_rnd};
    end else begin
      exp_rnd    = exp_base + {10'd0, carry_s};
      rnd_result = {32'hffff_ffff, sign_q, exp_rnd[7:0], frac_s_rnd};
    end
    rnd_nx = g | r | s;
  end

  always_comb begin
    state_d     = state_q;
    is_double_d = is_double_q;
    sign_d      = sign_q;
    rm_d        = rm_q;
    mag_d       = mag_q;
    lz_d        = lz_q;
    result_d    = result_q;
    flags_d     = flags_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid && !command[2]) begin
          is_double_d = command[1];
          sign_d      = src_sign;
          rm_d        = rounding_mode;
          mag_d       = src_mag;
          lz_d        = '0;
          if (src_mag == 64'd0) begin
            result_d = '0;
            flags_d  = '0;
            state_d  = StDone;
          end else begin
            state_d = StNormalize;
          end
        end
      end
      StNormalize: begin
`ifdef FP_INT64_CVT_LZC_EN
        mag_d   = mag_q << lzc;
        lz_d    = lzc;
        state_d = StRound;
`else
        if (mag_q[63]) begin
          state_d = StRound;
        end else if (mag_q[63 -: SHIFT_PER_CYCLE] == '0) begin
          mag_d = mag_q << SHIFT_PER_CYCLE;
          lz_d  = lz_q + 6'(SHIFT_PER_CYCLE);
        end else begin
          mag_d = mag_q << 1;
          lz_d  = lz_q + 6'd1;
        end
`endif
      end
      StRound: begin
        result_d = rnd_result;
        flags_d  = {4'd0, rnd_nx};
        state_d  = StDone;
      end
      StDone: begin
        if (resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      is_double_q <= 1'b0;
      sign_q      <= 1'b0;
      rm_q        <= '0;
      mag_q       <= '0;
      lz_q        <= '0;
      result_q    <= '0;
      flags_q     <= '0;
    end else begin
      state_q     <= state_d;
      is_double_q <= is_double_d;
      sign_q      <= sign_d;
      rm_q        <= rm_d;
      mag_q       <= mag_d;
      lz_q        <= lz_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
    end
  end

endmodule

// File: tb/tb_fp_int64_to_fp_serial.sv
// Self-checking bench for fp_int64_to_fp_serial: directed cases plus random conversions
// checked against an arithmetic reference model.
module tb_fp_int64_to_fp_serial;

  localparam int K = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  command;
  logic [2:0]  rounding_mode;
  logic [63:0] int_src;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] fp_result;
  logic [4:0]  write_flags_value;

  int n_checks = 0;
  int n_fail   = 0;

  fp_int64_to_fp_serial #(.SHIFT_PER_CYCLE(K)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .command           (command),
    .rounding_mode     (rounding_mode),
    .int_src           (int_src),
    .resp_valid        (resp_valid),
    .resp_ready        (resp_ready),
    .fp_result         (fp_result),
    .write_flags_value (write_flags_value)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: locate the leading one, keep F+1 significant bits, round on the discarded remainder.
  function automatic void model(input logic [2:0] cmd, input logic [2:0] rm, input logic [63:0] src,
                                output logic [63:0] res, output logic [4:0] fl, output int lat);
    bit          dbl, sgn, inc;
    int          p, fbits, bias, sh, e;
    logic [63:0] mag, q, rem, half;
    logic [10:0] ev;
    dbl = cmd[1];
    sgn = !cmd[0] && src[63];
    mag = sgn ? (~src + 64'd1) : src;
    res = '0;
    fl  = '0;
    lat = 1;
    if (mag == 64'd0) return;
    fbits = dbl ? 52 : 23;
    bias  = dbl ? 1023 : 127;
    p = 0;
    for (int i = 0; i < 64; i++) if (mag[i]) p = i;
    e = p + bias;
    if (p <= fbits) begin
      q = mag << (fbits - p);
    end else begin
      sh   = p - fbits;
      q    = mag >> sh;
      rem  = mag & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      fl[0] = (rem != 0);
      case (rm)
        3'd1:    inc = 0;
        3'd2:    inc = sgn && rem != 0;
        3'd3:    inc = !sgn && rem != 0;
        3'd4:    inc = rem >= half;
        default: inc = (rem > half) || (rem == half && q[0]);
      endcase
      q = q + 64'(inc);
      if (q == (64'd1 << (fbits + 1))) begin
        q = q >> 1;
        e++;
      end
    end
    ev = 11'(e);
    if (dbl) res = {sgn, ev, q[51:0]};
    else     res = {32'hffff_ffff, sgn, ev[7:0], q[22:0]};
`ifdef FP_INT64_CVT_LZC_EN
    lat = 3;
`else
    lat = (63 - p) / K + (63 - p) % K + 3;
`endif
  endfunction

  // Issue one request, wait for the response, hold it for 'hold' cycles, then handshake.
  task automatic do_txn(input string tag, input logic [2:0] cmd, input logic [2:0] rm,
                        input logic [63:0] src, input logic [63:0] exp_res,
                        input logic [4:0] exp_fl, input int exp_lat, input int hold);
    int          cyc;
    logic [63:0] held_res;
    logic [4:0]  held_fl;
    check({tag, " req_ready idle"}, 64'(req_ready), 64'd1);
    req_valid     = 1'b1;
    command       = cmd;
    rounding_mode = rm;
    int_src       = src;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    cyc = 1;
    while (!resp_valid && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, " latency"}, 64'(cyc), 64'(exp_lat));
    check({tag, " result"}, fp_result, exp_res);
    check({tag, " flags"}, 64'(write_flags_value), 64'(exp_fl));
    held_res = fp_result;
    held_fl  = write_flags_value;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({tag, " hold valid"}, 64'(resp_valid), 64'd1);
      check({tag, " hold result"}, fp_result, held_res);
      check({tag, " hold flags"}, 64'(write_flags_value), 64'(held_fl));
      check({tag, " hold req_ready"}, 64'(req_ready), 64'd0);
    end
    // A request presented alongside the handshake must not be taken.
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    command    = 3'd2;
    int_src    = 64'd5;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    req_valid  = 1'b0;
    check({tag, " post-hs valid"}, 64'(resp_valid), 64'd0);
    check({tag, " post-hs req_ready"}, 64'(req_ready), 64'd1);
    @(posedge clk);
    #1;
    check({tag, " no overlap accept"}, 64'(req_ready), 64'd1);
  endtask

  initial begin
    logic [63:0] src, eres;
    logic [4:0]  efl;
    logic [2:0]  cmd, rm;
    int          elat;

    rst_n         = 1'b0;
    req_valid     = 1'b0;
    resp_ready    = 1'b0;
    command       = '0;
    rounding_mode = '0;
    int_src       = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset req_ready", 64'(req_ready), 64'd1);
    check("reset resp_valid", 64'(resp_valid), 64'd0);
    check("reset result", fp_result, 64'd0);
    check("reset flags", 64'(write_flags_value), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    model(3'd2, 3'd0, 64'h0020_0000_0000_0001, eres, efl, elat);
    do_txn("dl 2^53+1 rne", 3'd2, 3'd0, 64'h0020_0000_0000_0001, 64'h4340_0000_0000_0000, 5'd1,
           elat, 0);
    do_txn("dl 2^53+1 rup", 3'd2, 3'd3, 64'h0020_0000_0000_0001, 64'h4340_0000_0000_0001, 5'd1,
           elat, 0);
`ifdef FP_INT64_CVT_LZC_EN
    elat = 3;
`else
    elat = 21;
`endif
    do_txn("sl -1", 3'd0, 3'd0, 64'hffff_ffff_ffff_ffff, 64'hffff_ffff_bf80_0000, 5'd0, elat, 0);
    do_txn("slu max rne", 3'd1, 3'd0, 64'hffff_ffff_ffff_ffff, 64'hffff_ffff_5f80_0000, 5'd1,
           3, 0);
    do_txn("slu max rtz", 3'd1, 3'd1, 64'hffff_ffff_ffff_ffff, 64'hffff_ffff_5f7f_ffff, 5'd1,
           3, 0);
    do_txn("dl min", 3'd2, 3'd0, 64'h8000_0000_0000_0000, 64'hc3e0_0000_0000_0000, 5'd0, 3, 5);
    do_txn("dlu zero", 3'd3, 3'd0, 64'd0, 64'd0, 5'd0, 1, 0);

    // Illegal command is consumed with no response.
    req_valid = 1'b1;
    command   = 3'd5;
    int_src   = 64'd7;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      check("illegal no resp", 64'(resp_valid), 64'd0);
    end
    check("illegal req_ready", 64'(req_ready), 64'd1);

    // Reset while normalizing.
    req_valid = 1'b1;
    command   = 3'd2;
    int_src   = 64'd1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort resp_valid", 64'(resp_valid), 64'd0);
    check("abort result", fp_result, 64'd0);
    check("abort req_ready", 64'(req_ready), 64'd1);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    model(3'd2, 3'd0, 64'd1, eres, efl, elat);
    do_txn("dl one after rst", 3'd2, 3'd0, 64'd1, 64'h3ff0_0000_0000_0000, 5'd0, elat, 0);

    for (int n = 0; n < 40; n++) begin
      cmd = 3'($urandom_range(0, 3));
      rm  = 3'($urandom_range(0, 7));
      src = {$urandom(), $urandom()} >> $urandom_range(0, 63);
      if ($urandom_range(0, 1) == 1) src = ~src + 64'd1;
      if ($urandom_range(0, 9) == 0) src = 64'd0;
      model(cmd, rm, src, eres, efl, elat);
      do_txn($sformatf("rand%0d cmd%0d rm%0d src%h", n, cmd, rm, src), cmd, rm, src, eres, efl,
             elat, n % 3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
